// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the bcd_to_bin_seq converter: FSM states and BCD digit constants.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_to_bin_seq_sub_3_cell.sv
// Reverse double-dabble digit correction: any digit >= 8 after the right shift loses 3.
module bcd_to_bin_seq_sub_3_cell
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din[BCD_DIGIT_W-1]) begin
      dout = din - BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double dabble), one result bit per clock.
// Define BCD_ERR_CHECK_EN to reject inputs containing a digit above 9 via err.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                            busy,
  output logic                            done,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            err
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [BCD_W-1:0]   bcd_fixed;
  logic [BIN_W-1:0]   bin_shifted;
  logic               last;
  logic               invalid;
  logic               accept;

  // Right shift of the concatenated {bcd, bin} register.
  assign bcd_shifted = bcd_q >> 1;
  assign bin_shifted = {bcd_q[0], bin_q[BIN_W-1:1]};
  assign last        = (cnt_q == '0);
  assign accept      = (state == IDLE) && start;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_to_bin_seq_sub_3_cell u_sub_3_cell (
      .din  (bcd_shifted[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_fixed[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_ERR_CHECK_EN
  logic err_q;

  always_comb begin
    invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
        invalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && invalid) begin
      err_q <= 1'b1;
    end else if ((state == SHIFT) && last) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign invalid = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = invalid ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // bin_out is captured from the final shift so it is valid on the same edge as DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
    end else begin
      if (accept) begin
        if (invalid) begin
          bin_out_q <= '0;
        end else begin
          bcd_q <= bcd_in;
          bin_q <= '0;
          cnt_q <= CNT_W'(BIN_W - 1);
        end
      end else if (state == SHIFT) begin
        bcd_q <= bcd_fixed;
        bin_q <= bin_shifted;
        if (last) begin
          bin_out_q <= bin_shifted;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign bin_out = bin_out_q;

endmodule
